// File: rtl/regfile_wb_sb.sv
// regfile_wb_sb
//   32-entry register file with a pending-write scoreboard.
//   Register 0 is hard-wired to zero and is never marked busy.
//
// Ports
//   clk, rst_n          rising-edge clock; synchronous active-low reset
//   rs_addr/rs_data     read port A (combinational, write-to-read bypass)
//   rt_addr/rt_data     read port B (combinational, write-to-read bypass)
//   dbg_addr/dbg_data   debug read port, registered, no bypass
//   iss_en/iss_addr     destination of an instruction leaving decode
//   wb_en/wb_addr/wb_data  write-back strobe, destination and data
//   rs_used/rt_used     read port is a real source this cycle
//   stall               combinational source hazard, holds decode
//   busy_vec            registered scoreboard bits
module regfile_wb_sb #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              iss_en,
   input  logic [4:0]        iss_addr,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              rs_used,
   input  logic              rt_used,
   output logic              stall,
   output logic [31:0]       busy_vec
);

   logic [DATA_W-1:0] regs_r [NREG];
   logic [31:0]       busy_r;
   logic [DATA_W-1:0] dbg_data_r;

   logic              wb_valid_s;
   logic              haz_a_s;
   logic              haz_b_s;
   logic              stall_s;
   logic [31:0]       set_vec_s;
   logic [31:0]       clr_vec_s;
   logic [31:0]       busy_next_s;
   logic [DATA_W-1:0] rs_data_s;
   logic [DATA_W-1:0] rt_data_s;

   // Writes to register 0 are dropped so it always reads zero.
   assign wb_valid_s = wb_en && (wb_addr != 5'd0);

   // Register array write; reset clears every entry and discards an in-flight write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_valid_s) begin
         regs_r[wb_addr] <= wb_data;
      end
   end

   // Read ports: a same-cycle write-back to the addressed register is forwarded.
   always_comb begin
      rs_data_s = '0;
      rt_data_s = '0;
      if (rs_addr == 5'd0) begin
         rs_data_s = '0;
      end else if (wb_en && (wb_addr == rs_addr)) begin
         rs_data_s = wb_data;
      end else begin
         rs_data_s = regs_r[rs_addr];
      end
      if (rt_addr == 5'd0) begin
         rt_data_s = '0;
      end else if (wb_en && (wb_addr == rt_addr)) begin
         rt_data_s = wb_data;
      end else begin
         rt_data_s = regs_r[rt_addr];
      end
   end

   assign rs_data = rs_data_s;
   assign rt_data = rt_data_s;

   // Source hazard: a pending write that is not being written back this cycle.
   always_comb begin
      haz_a_s = 1'b0;
      haz_b_s = 1'b0;
      if (rs_used && (rs_addr != 5'd0)) begin
         haz_a_s = busy_r[rs_addr] && !(wb_en && (wb_addr == rs_addr));
      end else begin
         haz_a_s = 1'b0;
      end
      if (rt_used && (rt_addr != 5'd0)) begin
         haz_b_s = busy_r[rt_addr] && !(wb_en && (wb_addr == rt_addr));
      end else begin
         haz_b_s = 1'b0;
      end
      stall_s = haz_a_s | haz_b_s;
   end

   assign stall = stall_s;

   // Scoreboard next state: a new issue outranks a write-back to the same register.
   always_comb begin
      set_vec_s = 32'd0;
      clr_vec_s = 32'd0;
      if (iss_en && !stall_s && (iss_addr != 5'd0)) begin
         set_vec_s = 32'd1 << iss_addr;
      end else begin
         set_vec_s = 32'd0;
      end
      if (wb_valid_s) begin
         clr_vec_s = 32'd1 << wb_addr;
      end else begin
         clr_vec_s = 32'd0;
      end
      busy_next_s = ((busy_r & ~clr_vec_s) | set_vec_s) & 32'hFFFF_FFFE;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= busy_next_s;
      end
   end

   assign busy_vec = busy_r;

   // Debug read: sampled from the array, so a same-cycle write shows a cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbg_data_r <= '0;
      end else begin
         dbg_data_r <= regs_r[dbg_addr];
      end
   end

   assign dbg_data = dbg_data_r;

endmodule
